multi_mul_sched: RTL and testbench
==================================

Name: multi_mul_sched

Overview:
Scheduler that sequences one multi_mul column-multiplier array through a full kernel pass.
- Pops weight columns from the weight FIFO and feature pixels from the input-feature buffer.
- Drives the multiplier's column/pixel enables and per-core enable mask, and tracks the active kernel column.
- Flags when multiplier products are valid for the downstream accumulator.
- Sits between the FIFOs/config registers and multi_mul.

Parameters:
NO_COL_KERNEL, 5, number of multiplier cores / max kernel columns
REG_WIDTH, 32, config register and counter width
MUL_LATENCY, 2, cycles from issue strobe to multiplier product valid (>=1)

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous reset, active high
i_start  in  1  pulse; begins a pass when idle
i_abort  in  1  synchronous abort; returns to IDLE without o_done
i_cfg_kernel_cols  in  3  kernel columns per pass (1..NO_COL_KERNEL)
i_cfg_pix_cnt  in  REG_WIDTH  feature pixels per kernel column
i_cfg_core_mask  in  NO_COL_KERNEL  cores to enable
i_wcol_valid  in  1  weight FIFO has a complete column
o_wcol_ready  out  1  pop weight column (valid&ready = transfer)
i_pix_valid  in  1  feature pixel available
o_pix_ready  out  1  pop pixel (valid&ready = transfer)
i_mul_ready  in  1  multi_mul ready (AND of core ready)
o_enable_colw  out  1  weight column enable to multiplier
o_enable_colip  out  1  input pixel enable to multiplier
o_enable_core  out  NO_COL_KERNEL  per-core enable
o_kercol_idx  out  3  current kernel column, 0-based
o_out_valid  out  1  product valid, MUL_LATENCY after issue
o_busy  out  1  high in any state except IDLE
o_done  out  1  one-cycle pulse at pass end
o_stall_cnt  out  REG_WIDTH  stall counter (optional feature)

Behaviour:
- Reset (async, i_rst=1): state IDLE. All outputs 0, all counters 0, valid shift register cleared. Takes effect immediately mid-pass; no o_done.
- Config latched on accepted i_start. Later config changes do not affect a running pass.
- i_cfg_kernel_cols of 0 or >NO_COL_KERNEL is clamped to NO_COL_KERNEL.
- i_start while o_busy is ignored.
- FSM:
  - IDLE: on i_start -> WLOAD; col_idx=0.
  - WLOAD: o_wcol_ready=1. On i_wcol_valid, the column is transferred and o_enable_colw goes high in the same cycle.
    - pix_cnt==0: go to NEXT (column consumed, no pixels).
    - otherwise: pix_idx=0, go to ISSUE.
  - ISSUE: o_enable_colw held 1. o_pix_ready = i_mul_ready.
    - On i_pix_valid&i_mul_ready: o_enable_colip=1 for exactly that cycle, issue strobe pushed into the MUL_LATENCY shift register, pix_idx++.
    - When pix_idx reaches pix_cnt-1 and the pixel is issued: go to NEXT.
    - Otherwise stay; o_enable_colip=0 in stall cycles.
  - NEXT: one cycle, enables 0.
    - col_idx==kernel_cols-1: go to DRAIN.
    - otherwise: col_idx++, go to WLOAD.
  - DRAIN: wait until the shift register is empty (at most MUL_LATENCY cycles) -> DONE.
  - DONE: o_done=1 for one cycle -> IDLE.
- o_enable_core = latched mask while state is ISSUE or WLOAD, else 0. Mask 0 still runs the full sequence.
- o_kercol_idx = col_idx. It wraps to 0 only on entering IDLE.
- o_out_valid = shift-register tail; it tracks issue strobes exactly, including stalls.
- i_abort: from any non-IDLE state -> IDLE next cycle. Shift register cleared, no o_done. i_abort has priority over i_start and all transfers in that cycle.
- Pixel counter is REG_WIDTH wide. pix_cnt up to 2^REG_WIDTH-1 is supported without wrap.

Optional Feature:
MULTI_MUL_SCHED_PERF_CNT_EN
- Defined: o_stall_cnt increments once per ISSUE cycle in which !(i_pix_valid&i_mul_ready), saturating at all-ones. Cleared on accepted i_start and on reset.
- Undefined: o_stall_cnt tied to 0, no counter logic.

Test Plan:
- kernel_cols=3, pix_cnt=4, FIFOs always valid, mul always ready -> 3 o_wcol_ready transfers; 12 o_enable_colip pulses; o_kercol_idx 0,1,2; 12 o_out_valid pulses each 2 cycles after issue; single o_done.
- Same config, i_pix_valid low 3 cycles mid-column 1 -> no o_enable_colip in those cycles; o_out_valid count still 12; o_stall_cnt=3 with PERF_CNT_EN.
- kernel_cols=0 -> clamps to 5; pix_cnt=0 -> 5 weight pops; zero o_enable_colip and zero o_out_valid; o_done asserted.
- i_abort during column 1 ISSUE -> IDLE next cycle; o_busy=0; no o_done; no further o_out_valid.
- i_rst asserted mid-DRAIN -> all outputs 0 immediately; a new i_start then completes a normal pass.
- i_start pulsed while busy and i_cfg_pix_cnt changed mid-pass -> ignored; pass completes with the originally latched count.

Source files
------------

// File: rtl/multi_mul_sched.sv
// multi_mul_sched: steps one multi_mul column-multiplier array through a full kernel pass.
// Optional stall counter on o_stall_cnt: define MULTI_MUL_SCHED_PERF_CNT_EN.
module multi_mul_sched #(
  parameter int NO_COL_KERNEL = 5,
  parameter int REG_WIDTH     = 32,
  parameter int MUL_LATENCY   = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic [2:0]               i_cfg_kernel_cols,
  input  logic [REG_WIDTH-1:0]     i_cfg_pix_cnt,
  input  logic [NO_COL_KERNEL-1:0] i_cfg_core_mask,
  input  logic                     i_wcol_valid,
  output logic                     o_wcol_ready,
  input  logic                     i_pix_valid,
  output logic                     o_pix_ready,
  input  logic                     i_mul_ready,
  output logic                     o_enable_colw,
  output logic                     o_enable_colip,
  output logic [NO_COL_KERNEL-1:0] o_enable_core,
  output logic [2:0]               o_kercol_idx,
  output logic                     o_out_valid,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [REG_WIDTH-1:0]     o_stall_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_WLOAD, S_ISSUE, S_NEXT, S_DRAIN, S_DONE
  } state_t;

  localparam logic [2:0] KCOLS_MAX = 3'(NO_COL_KERNEL);

  state_t                   r_state, w_state_next;
  logic [2:0]               r_kcols, r_col_idx, w_kcols_clamped;
  logic [REG_WIDTH-1:0]     r_pix_cnt, r_pix_idx;
  logic [NO_COL_KERNEL-1:0] r_mask;
  logic [MUL_LATENCY-1:0]   r_sr;
  logic                     w_start_acc, w_wcol_xfer, w_issue;
  logic                     w_last_pix, w_last_col, w_abort;

  // Abort outranks start and every handshake in the same cycle.
  assign w_abort     = i_abort && (r_state != S_IDLE);
  assign w_start_acc = (r_state == S_IDLE) && i_start && !i_abort;
  assign w_wcol_xfer = (r_state == S_WLOAD) && i_wcol_valid && !i_abort;
  assign w_issue     = (r_state == S_ISSUE) && i_pix_valid && i_mul_ready && !i_abort;
  assign w_last_pix  = (r_pix_idx == r_pix_cnt - REG_WIDTH'(1));
  assign w_last_col  = (r_col_idx == r_kcols - 3'd1);
  assign w_kcols_clamped = ((i_cfg_kernel_cols == 3'd0) || (i_cfg_kernel_cols > KCOLS_MAX))
                           ? KCOLS_MAX : i_cfg_kernel_cols;

  always_comb begin
    w_state_next   = r_state;
    o_wcol_ready   = 1'b0;
    o_pix_ready    = 1'b0;
    o_enable_colw  = 1'b0;
    o_enable_colip = 1'b0;
    o_enable_core  = '0;
    case (r_state)
      S_IDLE: if (w_start_acc) w_state_next = S_WLOAD;
      S_WLOAD: begin
        o_wcol_ready  = !i_abort;
        o_enable_colw = w_wcol_xfer;
        o_enable_core = r_mask;
        if (w_wcol_xfer) w_state_next = (r_pix_cnt == '0) ? S_NEXT : S_ISSUE;
      end
      S_ISSUE: begin
        o_enable_colw  = 1'b1;
        o_pix_ready    = i_mul_ready && !i_abort;
        o_enable_colip = w_issue;
        o_enable_core  = r_mask;
        if (w_issue && w_last_pix) w_state_next = S_NEXT;
      end
      S_NEXT:  w_state_next = w_last_col ? S_DRAIN : S_WLOAD;
      S_DRAIN: if (r_sr == '0) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (w_abort) w_state_next = S_IDLE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_kcols   <= '0;
      r_pix_cnt <= '0;
      r_mask    <= '0;
      r_col_idx <= '0;
      r_pix_idx <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_start_acc) begin
        r_kcols   <= w_kcols_clamped;
        r_pix_cnt <= i_cfg_pix_cnt;
        r_mask    <= i_cfg_core_mask;
      end
      if (w_state_next == S_IDLE)
        r_col_idx <= '0;
      else if ((r_state == S_NEXT) && !w_last_col)
        r_col_idx <= r_col_idx + 3'd1;
      if (w_wcol_xfer)
        r_pix_idx <= '0;
      else if (w_issue)
        r_pix_idx <= r_pix_idx + REG_WIDTH'(1);
    end
  end

  // Issue strobes travel down r_sr; the tail marks a valid product.
  generate
    if (MUL_LATENCY == 1) begin : g_sr_single
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)        r_sr <= '0;
        else if (w_abort) r_sr <= '0;
        else              r_sr <= w_issue;
      end
    end else begin : g_sr_multi
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)        r_sr <= '0;
        else if (w_abort) r_sr <= '0;
        else              r_sr <= {r_sr[MUL_LATENCY-2:0], w_issue};
      end
    end
  endgenerate

`ifdef MULTI_MUL_SCHED_PERF_CNT_EN
  logic [REG_WIDTH-1:0] r_stall_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_stall_cnt <= '0;
    else if (w_start_acc)
      r_stall_cnt <= '0;
    else if ((r_state == S_ISSUE) && !(i_pix_valid && i_mul_ready) && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + REG_WIDTH'(1);
  end

  assign o_stall_cnt = r_stall_cnt;
`else
  assign o_stall_cnt = '0;
`endif

  assign o_kercol_idx = r_col_idx;
  assign o_out_valid  = r_sr[MUL_LATENCY-1];
  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = (r_state == S_DONE);

endmodule

// File: tb/tb_multi_mul_sched.sv
// tb_multi_mul_sched: directed, table-driven bench for the multi_mul_sched pass sequencer.
// Stall counter expectations follow MULTI_MUL_SCHED_PERF_CNT_EN.
module tb_multi_mul_sched;
  localparam int NCK = 5;
  localparam int RW  = 32;
  localparam int ML  = 2;

  logic           clk = 1'b0;
  logic           rst, start, abort;
  logic [2:0]     cfgKc;
  logic [RW-1:0]  cfgPc;
  logic [NCK-1:0] cfgMask;
  logic           wcolValid, pixValid, mulReady;
  logic           o_wcol_ready, o_pix_ready, o_enable_colw, o_enable_colip;
  logic [NCK-1:0] o_enable_core;
  logic [2:0]     o_kercol_idx;
  logic           o_out_valid, o_busy, o_done;
  logic [RW-1:0]  o_stall_cnt;

  multi_mul_sched #(.NO_COL_KERNEL(NCK), .REG_WIDTH(RW), .MUL_LATENCY(ML)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_cfg_kernel_cols(cfgKc), .i_cfg_pix_cnt(cfgPc), .i_cfg_core_mask(cfgMask),
    .i_wcol_valid(wcolValid), .o_wcol_ready(o_wcol_ready),
    .i_pix_valid(pixValid), .o_pix_ready(o_pix_ready), .i_mul_ready(mulReady),
    .o_enable_colw(o_enable_colw), .o_enable_colip(o_enable_colip),
    .o_enable_core(o_enable_core), .o_kercol_idx(o_kercol_idx),
    .o_out_valid(o_out_valid), .o_busy(o_busy), .o_done(o_done),
    .o_stall_cnt(o_stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]     kc;
    logic [RW-1:0]  pc;
    logic [NCK-1:0] mask;
    int             expPops;
    int             expColip;
    int             expOutv;
  } vec_t;

  vec_t vecs[6];

  int checks = 0, failures = 0;
  int monPops = 0, monColip = 0, monOutv = 0, monDone = 0, passPops = 0;
  int kercolErr = 0, coreErr = 0, latErr = 0, stallColipErr = 0;
  logic [ML-1:0]  hist = '0;
  logic [NCK-1:0] expMask = '0;

  // Observes every cycle: counts transfers, and checks each o_out_valid against
  // the issue strobe seen ML cycles earlier (cleared by abort or reset).
  always @(negedge clk) begin
    if (rst) begin
      hist     <= '0;
      passPops <= 0;
    end else begin
      if (o_out_valid !== hist[ML-1]) latErr <= latErr + 1;
      if (abort && o_busy) hist <= '0;
      else                 hist <= {hist[ML-2:0], o_enable_colip};
      if (!o_busy) passPops <= 0;
      else if (o_wcol_ready && wcolValid) begin
        if (o_kercol_idx !== 3'(passPops)) kercolErr <= kercolErr + 1;
        passPops <= passPops + 1;
        monPops  <= monPops + 1;
      end
      if (o_enable_colip) begin
        monColip <= monColip + 1;
        if (o_enable_core !== expMask) coreErr <= coreErr + 1;
        if (!pixValid || !mulReady) stallColipErr <= stallColipErr + 1;
      end
      if (o_out_valid) monOutv <= monOutv + 1;
      if (o_done)      monDone <= monDone + 1;
    end
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic startPass(input logic [2:0] kc, input logic [RW-1:0] pc, input logic [NCK-1:0] mask);
    @(posedge clk); #1;
    cfgKc   = kc;
    cfgPc   = pc;
    cfgMask = mask;
    expMask = mask;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic waitDone(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (o_done) begin
        seen = 1'b1;
        break;
      end
    end
    #1;
  endtask

  task automatic waitCol1Issue(output bit found);
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (o_kercol_idx == 3'd1 && o_enable_colip) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input string name, input vec_t v);
    int p0, c0, o0, d0;
    bit seen;
    p0 = monPops; c0 = monColip; o0 = monOutv; d0 = monDone;
    startPass(v.kc, v.pc, v.mask);
    waitDone(seen);
    checkOutput({name, "_done_seen"}, seen, 1);
    checkOutput({name, "_wcol_pops"}, monPops - p0, v.expPops);
    checkOutput({name, "_colip_pulses"}, monColip - c0, v.expColip);
    checkOutput({name, "_out_valid"}, monOutv - o0, v.expOutv);
    @(negedge clk); #1;
    checkOutput({name, "_done_once"}, monDone - d0, 1);
    checkOutput({name, "_idle_after"}, {o_busy, o_kercol_idx}, 0);
  endtask

  initial begin
    bit seen, found;
    int p0, c0, o0, d0;

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfgKc = '0; cfgPc = '0; cfgMask = '0;
    wcolValid = 1'b1; pixValid = 1'b1; mulReady = 1'b1;

    vecs[0] = '{3'd3, 32'd4, 5'h1F, 3, 12, 12};
    vecs[1] = '{3'd0, 32'd0, 5'h1F, 5, 0, 0};
    vecs[2] = '{3'd7, 32'd1, 5'h0A, 5, 5, 5};
    vecs[3] = '{3'd1, 32'd1, 5'h00, 1, 1, 1};
    vecs[4] = '{3'd5, 32'd2, 5'h10, 5, 10, 10};
    vecs[5] = '{3'd2, 32'd3, 5'h03, 2, 6, 6};

    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", {o_busy, o_done, o_out_valid, o_wcol_ready, o_pix_ready,
                                  o_enable_colw, o_enable_colip, o_enable_core, o_kercol_idx,
                                  o_stall_cnt}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 6; i++) applyStimulus($sformatf("vec%0d", i), vecs[i]);

    // Three stalled pixel cycles inside column 1.
    p0 = monPops; c0 = monColip; o0 = monOutv; d0 = monDone;
    startPass(3'd3, 32'd4, 5'h1F);
    waitCol1Issue(found);
    checkOutput("stall_reach_col1", found, 1);
    @(posedge clk); #1;
    pixValid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    pixValid = 1'b1;
    waitDone(seen);
    checkOutput("stall_done_seen", seen, 1);
    checkOutput("stall_wcol_pops", monPops - p0, 3);
    checkOutput("stall_colip_pulses", monColip - c0, 12);
    checkOutput("stall_out_valid", monOutv - o0, 12);
    checkOutput("stall_done_once", monDone - d0, 1);
`ifdef MULTI_MUL_SCHED_PERF_CNT_EN
    checkOutput("stall_cnt", o_stall_cnt, 3);
`else
    checkOutput("stall_cnt_tied", o_stall_cnt, 0);
`endif

    // Abort in the middle of column 1.
    d0 = monDone;
    startPass(3'd3, 32'd4, 5'h1F);
    waitCol1Issue(found);
    checkOutput("abort_reach_col1", found, 1);
    @(posedge clk); #1;
    abort = 1'b1;
    @(negedge clk);
    checkOutput("abort_cycle_busy", o_busy, 1);
    checkOutput("abort_cycle_no_issue", {o_enable_colip, o_pix_ready}, 0);
    #1;
    o0 = monOutv;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    checkOutput("abort_idle_next", {o_busy, o_kercol_idx}, 0);
    repeat (10) @(negedge clk);
    #1;
    checkOutput("abort_no_out_valid", monOutv - o0, 0);
    checkOutput("abort_no_done", monDone - d0, 0);

    // Asynchronous reset while draining, then a normal pass.
    d0 = monDone;
    startPass(3'd1, 32'd1, 5'h07);
    found = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (o_busy && o_out_valid && !o_enable_colw) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("rst_reach_drain", found, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_outputs_immediate", {o_busy, o_done, o_out_valid, o_wcol_ready, o_pix_ready,
                                          o_enable_colw, o_enable_colip, o_enable_core,
                                          o_kercol_idx, o_stall_cnt}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    checkOutput("rst_no_done", monDone - d0, 0);
    applyStimulus("post_rst", vecs[0]);

    // Start pulse and config change while busy must not disturb the pass.
    p0 = monPops; c0 = monColip; o0 = monOutv; d0 = monDone;
    startPass(3'd2, 32'd3, 5'h03);
    repeat (3) @(posedge clk);
    #1;
    cfgPc = 32'd7; cfgKc = 3'd5; cfgMask = 5'h1F;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone(seen);
    checkOutput("busy_start_done_seen", seen, 1);
    checkOutput("busy_start_pops", monPops - p0, 2);
    checkOutput("busy_start_colip", monColip - c0, 6);
    checkOutput("busy_start_out_valid", monOutv - o0, 6);
    repeat (30) @(negedge clk);
    #1;
    checkOutput("busy_start_single_pass", {o_busy, 8'(monDone - d0)}, 1);

    checkOutput("kercol_idx_errors", kercolErr, 0);
    checkOutput("core_enable_errors", coreErr, 0);
    checkOutput("out_valid_latency_errors", latErr, 0);
    checkOutput("colip_in_stall_errors", stallColipErr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
